multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_ctrl_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and its datapath: states, opcodes,
// ALU operation and ALU source-B select values, plus small opcode classification helpers.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [5:0] OpAnd = 6'h00;
  localparam logic [5:0] OpOr  = 6'h01;
  localparam logic [5:0] OpAdd = 6'h02;
  localparam logic [5:0] OpSub = 6'h06;
  localparam logic [5:0] OpSlt = 6'h07;
  localparam logic [5:0] OpLw  = 6'h08;
  localparam logic [5:0] OpSw  = 6'h0A;
  localparam logic [5:0] OpBne = 6'h0E;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  typedef enum logic [1:0] {
    ClsRType,
    ClsMem,
    ClsBne,
    ClsIllegal
  } op_class_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  // All six opcode bits take part; anything outside the table is illegal.
  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e cls;
    unique case (op)
      OpAnd, OpOr, OpAdd, OpSub, OpSlt: cls = ClsRType;
      OpLw, OpSw:                       cls = ClsMem;
      OpBne:                            cls = ClsBne;
      default:                          cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [2:0] rtype_alu_op(input logic [5:0] op);
    logic [2:0] aop;
    unique case (op)
      OpOr:    aop = AluOr;
      OpAdd:   aop = AluAdd;
      OpSub:   aop = AluSub;
      OpSlt:   aop = AluSlt;
      default: aop = AluAnd;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait watchdog: counts consecutive not-ready cycles in FETCH/MEM and flags when the
// count has reached WAIT_MAX.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CntW'(WAIT_MAX));

  // Saturate at WAIT_MAX so a stalled count can never wrap back past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a latched opcode and
// a memory wait watchdog that parks the machine in HALT until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [2:0] ALU_op,
  output logic       instr_done,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  op_class_e  op_cls;
  logic       in_mem_phase;
  logic       wait_expired;
  ctrl_t      ctrl;

  assign op_cls       = op_class(op_q);
  assign in_mem_phase = (state_q == StFetch) || (state_q == StMem);

  // Clearing on acceptance as well as outside FETCH/MEM means every FETCH/MEM visit starts at 0,
  // including the direct MEM -> FETCH hop of a store.
  mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_mem_phase || mem_ready),
    .tick   (in_mem_phase && !mem_ready),
    .expired(wait_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StHalt;
        end
      end
      StDecode: begin
        state_d = (op_class(opcode) == ClsIllegal) ? StHalt : StExec;
      end
      StExec: begin
        unique case (op_cls)
          ClsRType: state_d = StWb;
          ClsMem:   state_d = StMem;
          ClsBne:   state_d = StFetch;
          default:  state_d = StHalt;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (op_q == OpLw) ? StWb : StFetch;
        end else if (wait_expired) begin
          state_d = StHalt;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluAdd;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end
      end
      StDecode: begin
      end
      StExec: begin
        unique case (op_cls)
          ClsRType: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_op    = rtype_alu_op(op_q);
          end
          ClsMem: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluAdd;
          end
          ClsBne: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SrcBReg;
            ctrl.alu_op     = AluSub;
            ctrl.pc_write   = !zero;
            ctrl.pc_src     = !zero;
            ctrl.instr_done = 1'b1;
          end
          default: begin
          end
        endcase
      end
      StMem: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_read   = (op_q == OpLw);
        ctrl.mem_write  = (op_q == OpSw);
        ctrl.instr_done = mem_ready && (op_q == OpSw);
      end
      StWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        ctrl.mem_to_reg = (op_q == OpLw);
        ctrl.reg_dst    = (op_q != OpLw);
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      default: begin
      end
    endcase
    // Outputs are forced quiet for the whole reset cycle, whatever state we were in.
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign PCSrc      = ctrl.pc_src;
  assign RegWrite   = ctrl.reg_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemToReg   = ctrl.mem_to_reg;
  assign ALU_srcA   = ctrl.alu_src_a;
  assign ALU_srcB   = ctrl.alu_src_b;
  assign ALU_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign halted     = ctrl.halted;

endmodule
